// File: rtl/bp_retire_sched.sv
// rtl/bp_retire_sched.sv - retire-side branch predictor update scheduler
//
// Buffers up to two retired-branch updates per cycle in an in-order FIFO and
// drains one per cycle onto the single BP rt_* update port. Issuing a
// mispredicted update starts a recovery hold: no further updates are issued
// for RECOVER_CYCLES cycles, and fetch is stalled while any mispredict is
// queued or recovery is in progress.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   enable                       low freezes all state (no enqueue/dequeue)
//   rt0_* / rt1_*                retiring branches, slot 0 older
//   rt_ready                     two or more free entries, retire may present
//   bp_rt_en_branch              head update valid to BP
//   bp_rt_*                      head entry fields (zero when empty)
//   fetch_stall                  fetch must not present if_branch to BP
//   count                        occupied entries
module bp_retire_sched #(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int OBQ_SIZE       = 16,
    parameter int IDX_W          = $clog2(OBQ_SIZE) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       rt0_valid,
    input  logic                       rt0_taken,
    input  logic                       rt0_correct,
    input  logic [31:0]                rt0_pc,
    input  logic [31:0]                rt0_target,
    input  logic [IDX_W-1:0]           rt0_index,
    input  logic                       rt1_valid,
    input  logic                       rt1_taken,
    input  logic                       rt1_correct,
    input  logic [31:0]                rt1_pc,
    input  logic [31:0]                rt1_target,
    input  logic [IDX_W-1:0]           rt1_index,
    output logic                       rt_ready,
    output logic                       bp_rt_en_branch,
    output logic                       bp_rt_branch_taken,
    output logic                       bp_rt_prediction_correct,
    output logic [31:0]                bp_rt_pc,
    output logic [31:0]                bp_rt_calculated_pc,
    output logic [IDX_W-1:0]           bp_rt_branch_index,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic {
        ST_DRAIN   = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0] head, tail, tail_p1;
    logic [CNT_W-1:0] cnt_q, mp_count;
    logic [RC_W-1:0]  rc_cnt;

    logic             taken_mem   [DEPTH];
    logic             correct_mem [DEPTH];
    logic [31:0]      pc_mem      [DEPTH];
    logic [31:0]      target_mem  [DEPTH];
    logic [IDX_W-1:0] index_mem   [DEPTH];

    logic             enq0, enq1, deq;
    logic [CNT_W-1:0] enq_n, deq_n, mp_in, mp_out;
    logic             head_valid;

    assign tail_p1    = tail + PTR_W'(1);
    assign head_valid = (cnt_q != '0);

    // Two free slots are required so a full pair can always be accepted.
    assign rt_ready = enable && (cnt_q <= CNT_W'(DEPTH - 2));

    // A lone rt1 is a protocol error and is dropped.
    assign enq0 = rt_ready && rt0_valid;
    assign enq1 = rt_ready && rt0_valid && rt1_valid;

    assign bp_rt_en_branch = enable && head_valid && (state == ST_DRAIN);
    assign deq             = bp_rt_en_branch;

    assign enq_n  = CNT_W'(enq0) + CNT_W'(enq1);
    assign deq_n  = CNT_W'(deq);
    assign mp_in  = CNT_W'(enq0 && !rt0_correct) + CNT_W'(enq1 && !rt1_correct);
    assign mp_out = CNT_W'(deq && !correct_mem[head]);

    assign bp_rt_branch_taken       = head_valid ? taken_mem[head]   : 1'b0;
    assign bp_rt_prediction_correct = head_valid ? correct_mem[head] : 1'b0;
    assign bp_rt_pc                 = head_valid ? pc_mem[head]      : 32'h0;
    assign bp_rt_calculated_pc      = head_valid ? target_mem[head]  : 32'h0;
    assign bp_rt_branch_index       = head_valid ? index_mem[head]   : '0;

    assign fetch_stall = (mp_count != '0) || (state == ST_RECOVER);
    assign count       = cnt_q;

    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                ST_DRAIN:   if (deq && !correct_mem[head]) state_next = ST_RECOVER;
                ST_RECOVER: if (rc_cnt == RC_W'(1))         state_next = ST_DRAIN;
                default:    state_next = ST_DRAIN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_DRAIN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            cnt_q    <= '0;
            mp_count <= '0;
            rc_cnt   <= '0;
        end else if (enable) begin
            if (deq)  head <= head + PTR_W'(1);
            if (enq1) tail <= tail + PTR_W'(2);
            else if (enq0) tail <= tail_p1;
            cnt_q    <= cnt_q + enq_n - deq_n;
            mp_count <= mp_count + mp_in - mp_out;
            // Load on issue of a mispredict; count down while recovering.
            if (state == ST_DRAIN && deq && !correct_mem[head]) begin
                rc_cnt <= RC_W'(RECOVER_CYCLES);
            end else if (state == ST_RECOVER && rc_cnt != '0) begin
                rc_cnt <= rc_cnt - RC_W'(1);
            end
        end
    end

    // Payload storage needs no reset: the output path gates on occupancy.
    always_ff @(posedge clock) begin
        if (!reset && enq0) begin
            taken_mem[tail]   <= rt0_taken;
            correct_mem[tail] <= rt0_correct;
            pc_mem[tail]      <= rt0_pc;
            target_mem[tail]  <= rt0_target;
            index_mem[tail]   <= rt0_index;
        end
        if (!reset && enq1) begin
            taken_mem[tail_p1]   <= rt1_taken;
            correct_mem[tail_p1] <= rt1_correct;
            pc_mem[tail_p1]      <= rt1_pc;
            target_mem[tail_p1]  <= rt1_target;
            index_mem[tail_p1]   <= rt1_index;
        end
    end

endmodule
